// File: rtl/cmd_sequencer.sv
// SD host CMD-line sequencer: builds the 48-bit command frame with a serial CRC7,
// drives the CMD PHY handshake, checks the response and handles timeout/abort/retry.
module cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int MAX_RETRIES    = 2,
    parameter int RETRY_W        = 2
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic         new_command,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         abort_req,
    input  logic         phy_strobe_in,
    input  logic         phy_ack_in,
    input  logic         phy_timeout_in,
    input  logic [135:0] phy_response,
    output logic         phy_strobe_out,
    output logic         phy_ack_out,
    output logic         phy_idle_out,
    output logic         phy_no_response,
    output logic [47:0]  cmd_frame,
    output logic [127:0] response,
    output logic         busy,
    output logic         cmd_done,
    output logic         timeout_error,
    output logic         crc_error,
    output logic         index_error,
    output logic         end_bit_error
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, CRC_GEN, ISSUE, WAIT_RESP, CRC_CHK, ACK, ACK_WAIT, ABORT, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         index_q, index_d;
    logic [31:0]        arg_q, arg_d;
    logic [1:0]         type_q, type_d;
    logic [127:0]       resp_q, resp_d;
    logic [47:0]        frame_q, frame_d;
    logic [127:0]       response_q, response_d;
    logic [6:0]         crc_q, crc_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic               phase_q, phase_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               sw_abort_q, sw_abort_d;
    logic               tmo_err_q, tmo_err_d;
    logic               crc_err_q, crc_err_d;
    logic               idx_err_q, idx_err_d;
    logic               end_err_q, end_err_d;

    logic [39:0] gen_bits;
    logic [39:0] crc_src;
    logic        crc_in_bit;
    logic        crc_fb;
    logic [6:0]  crc_step;
    logic        can_retry;
    logic        sw_abort;
    logic        unused_resp_hi;

    // The R2 start/reserved byte carries nothing the host reports.
    assign unused_resp_hi = ^phy_response[135:128];

    assign gen_bits   = {2'b01, index_q, arg_q};
    assign crc_src    = (state_q == CRC_GEN) ? gen_bits : resp_q[47:8];
    assign crc_in_bit = crc_src[6'd39 - bit_cnt_q];
    assign crc_fb     = crc_in_bit ^ crc_q[6];
    assign crc_step   = {crc_q[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
    assign can_retry  = retry_q < RETRY_W'(MAX_RETRIES);
    assign sw_abort   = sw_abort_q | abort_req;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        arg_d      = arg_q;
        type_d     = type_q;
        resp_d     = resp_q;
        frame_d    = frame_q;
        response_d = response_q;
        crc_d      = crc_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = 1'b0;
        wd_d       = wd_q;
        retry_d    = retry_q;
        sw_abort_d = sw_abort_q;
        tmo_err_d  = tmo_err_q;
        crc_err_d  = crc_err_q;
        idx_err_d  = idx_err_q;
        end_err_d  = end_err_q;

        case (state_q)
            IDLE: begin
                if (new_command) begin
                    index_d    = cmd_index;
                    arg_d      = cmd_arg;
                    type_d     = resp_type;
                    tmo_err_d  = 1'b0;
                    crc_err_d  = 1'b0;
                    idx_err_d  = 1'b0;
                    end_err_d  = 1'b0;
                    retry_d    = '0;
                    sw_abort_d = 1'b0;
                    crc_d      = '0;
                    bit_cnt_d  = '0;
                    state_d    = CRC_GEN;
                end
            end
            CRC_GEN: begin
                crc_d     = crc_step;
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd39) begin
                    frame_d = {gen_bits, crc_step, 1'b1};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    wd_d    = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                wd_d = wd_q + 1'b1;
                // A response arriving on the expiry cycle takes priority.
                if (phy_strobe_in) begin
                    resp_d = phy_response[127:0];
                    case (type_q)
                        2'b00: state_d = DONE;
                        2'b01: begin
                            crc_d     = '0;
                            bit_cnt_d = '0;
                            state_d   = CRC_CHK;
                        end
                        default: state_d = ACK;
                    endcase
                end else if (phy_timeout_in || wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    sw_abort_d = 1'b0;
                    state_d    = ABORT;
                end
            end
            CRC_CHK: begin
                crc_d     = crc_step;
                bit_cnt_d = bit_cnt_q + 6'd1;
                if (bit_cnt_q == 6'd39) begin
                    crc_err_d = (crc_step != resp_q[7:1]);
                    idx_err_d = (resp_q[45:40] != index_q);
                    end_err_d = ~resp_q[0];
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (phy_ack_in) state_d = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (crc_err_q && !idx_err_q && !end_err_q && can_retry) begin
                    retry_d   = retry_q + RETRY_W'(1);
                    crc_err_d = 1'b0;
                    state_d   = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            ABORT: begin
                sw_abort_d = sw_abort;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (!sw_abort && can_retry) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = ISSUE;
                end else begin
                    tmo_err_d = tmo_err_q | ~sw_abort;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_req && (state_q inside {CRC_GEN, ISSUE, WAIT_RESP, CRC_CHK, ACK, ACK_WAIT})) begin
            sw_abort_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = ABORT;
        end

        if (state_d == DONE && state_q != DONE) begin
            if (state_q == ABORT || type_q == 2'b00) response_d = '0;
            else if (type_q == 2'b10)                response_d = resp_q;
            else                                     response_d = {88'b0, resp_q[39:8]};
        end
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            arg_q      <= '0;
            type_q     <= '0;
            resp_q     <= '0;
            frame_q    <= '0;
            response_q <= '0;
            crc_q      <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= 1'b0;
            wd_q       <= '0;
            retry_q    <= '0;
            sw_abort_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            crc_err_q  <= 1'b0;
            idx_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            arg_q      <= arg_d;
            type_q     <= type_d;
            resp_q     <= resp_d;
            frame_q    <= frame_d;
            response_q <= response_d;
            crc_q      <= crc_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            wd_q       <= wd_d;
            retry_q    <= retry_d;
            sw_abort_q <= sw_abort_d;
            tmo_err_q  <= tmo_err_d;
            crc_err_q  <= crc_err_d;
            idx_err_q  <= idx_err_d;
            end_err_q  <= end_err_d;
        end
    end

    assign phy_strobe_out  = (state_q == ISSUE);
    assign phy_ack_out     = (state_q == ACK);
    assign phy_idle_out    = (state_q == ABORT);
    assign phy_no_response = (type_q == 2'b00) &&
                             (state_q inside {ISSUE, WAIT_RESP, CRC_CHK, ACK, ACK_WAIT, ABORT});
    assign busy            = (state_q != IDLE) && (state_q != DONE);
    assign cmd_done        = (state_q == DONE);
    assign cmd_frame       = frame_q;
    assign response        = response_q;
    assign timeout_error   = tmo_err_q;
    assign crc_error       = crc_err_q;
    assign index_error     = idx_err_q;
    assign end_bit_error   = end_err_q;
endmodule
